// File: rtl/sd_clk_ctrl.sv
// SD-bus clock sequencer: PLL-lock startup, programmable half-period, safe divider switch.
// Optional macro SD_CLK_STRETCH_EN adds i_hold to stretch the low phase at the rising boundary.
module sd_clk_ctrl #(
    parameter int DIV_W       = 8,
    parameter int INIT_DIV    = 250,
    parameter int LOCK_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pll_lock,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_req,
`ifdef SD_CLK_STRETCH_EN
    input  logic             i_hold,
`endif
    output logic             o_div_ack,
    output logic [DIV_W-1:0] o_cur_div,
    output logic             o_sd_clk,
    output logic             o_rise_stb,
    output logic             o_fall_stb,
    output logic             o_ready
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           r_state;
    logic [LCW-1:0]   r_lock_cnt;
    logic [DIV_W-1:0] r_cnt;
    logic             r_sd_clk;
    logic             r_rise;
    logic             r_fall;
    logic             r_ack;
    logic             r_ready;
    logic [DIV_W-1:0] r_cur_div;

    state_t           w_state_nxt;
    logic [LCW-1:0]   w_lock_cnt_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_sd_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_ack_nxt;
    logic [DIV_W-1:0] w_cur_div_nxt;

    logic             w_hold;
    logic             w_req;
    logic [DIV_W-1:0] w_req_div;
    logic             w_boundary;
    logic             w_apply;
    logic [DIV_W-1:0] w_div_eff;

`ifdef SD_CLK_STRETCH_EN
    assign w_hold = i_hold;
`else
    assign w_hold = 1'b0;
`endif

    // A req still high right after an ack is a fresh request, one cycle later.
    assign w_req      = i_div_req & ~r_ack;
    assign w_req_div  = (i_div == '0) ? DIV_W'(1) : i_div;
    assign w_boundary = (r_state == ST_RUN) && !r_sd_clk && (r_cnt == '0);
    assign w_apply    = w_req && i_pll_lock &&
                        ((r_state == ST_IDLE) || (w_boundary && !w_hold));
    assign w_div_eff  = w_apply ? w_req_div : r_cur_div;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_STARTUP;
            r_lock_cnt <= '0;
            r_cnt      <= '0;
            r_sd_clk   <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_ack      <= 1'b0;
            r_ready    <= 1'b0;
            r_cur_div  <= DIV_W'(INIT_DIV);
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sd_clk   <= w_sd_nxt;
            r_rise     <= w_rise_nxt;
            r_fall     <= w_fall_nxt;
            r_ack      <= w_ack_nxt;
            r_ready    <= (w_state_nxt != ST_STARTUP);
            r_cur_div  <= w_cur_div_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = '0;
        unique case (r_state)
            ST_STARTUP: begin
                if (!i_pll_lock) begin
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == LCW'(LOCK_CYCLES)) begin
                    w_lock_cnt_nxt = r_lock_cnt;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
                end
            end
            ST_IDLE: begin
                if (!i_pll_lock)
                    w_state_nxt = ST_STARTUP;
                else if (i_run)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!i_pll_lock)
                    w_state_nxt = ST_STARTUP;
                else if (w_boundary && !w_hold && !i_run)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_STARTUP;
        endcase
    end

    always_comb begin
        w_sd_nxt      = r_sd_clk;
        w_rise_nxt    = 1'b0;
        w_fall_nxt    = 1'b0;
        w_ack_nxt     = 1'b0;
        w_cur_div_nxt = r_cur_div;
        w_cnt_nxt     = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_sd_nxt = 1'b0;
                if (i_pll_lock) begin
                    if (w_apply) begin
                        w_ack_nxt     = 1'b1;
                        w_cur_div_nxt = w_req_div;
                    end
                    if (i_run) begin
                        w_sd_nxt   = 1'b1;
                        w_rise_nxt = 1'b1;
                        w_cnt_nxt  = w_div_eff - DIV_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!i_pll_lock) begin
                    w_sd_nxt  = 1'b0;
                    w_cnt_nxt = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DIV_W'(1);
                end else if (r_sd_clk) begin
                    w_sd_nxt   = 1'b0;
                    w_fall_nxt = 1'b1;
                    w_cnt_nxt  = r_cur_div - DIV_W'(1);
                end else if (!w_hold) begin
                    // Rising boundary: the only safe point to switch rate.
                    if (w_apply) begin
                        w_ack_nxt     = 1'b1;
                        w_cur_div_nxt = w_req_div;
                    end
                    if (i_run) begin
                        w_sd_nxt   = 1'b1;
                        w_rise_nxt = 1'b1;
                        w_cnt_nxt  = w_div_eff - DIV_W'(1);
                    end
                end
            end
            default: begin
                w_sd_nxt  = 1'b0;
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign o_sd_clk   = r_sd_clk;
    assign o_rise_stb = r_rise;
    assign o_fall_stb = r_fall;
    assign o_div_ack  = r_ack;
    assign o_ready    = r_ready;
    assign o_cur_div  = r_cur_div;

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// Self-checking bench for sd_clk_ctrl: vector table plus startup, lock-loss and reset sequences.
// Build with SD_CLK_STRETCH_EN defined to also exercise the low-phase stretch.
module tb_sd_clk_ctrl;

    typedef struct packed {
        logic       sd;
        logic       rise;
        logic       fall;
        logic       ack;
        logic       rdy;
        logic [7:0] cur;
    } out_t;

    typedef struct {
        logic       run;
        logic       req;
        logic [7:0] div;
        out_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock;
    logic       run;
    logic [7:0] div;
    logic       req;
    logic       hold;
    logic       ack;
    logic [7:0] cur;
    logic       sd;
    logic       rise;
    logic       fall;
    logic       rdy;

    int   n_chk  = 0;
    int   n_fail = 0;
    out_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    sd_clk_ctrl #(.DIV_W(8), .INIT_DIV(250), .LOCK_CYCLES(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pll_lock (lock),
        .i_run      (run),
        .i_div      (div),
        .i_div_req  (req),
`ifdef SD_CLK_STRETCH_EN
        .i_hold     (hold),
`endif
        .o_div_ack  (ack),
        .o_cur_div  (cur),
        .o_sd_clk   (sd),
        .o_rise_stb (rise),
        .o_fall_stb (fall),
        .o_ready    (rdy)
    );

    function automatic out_t mk(logic s, logic r, logic f, logic a,
                                logic y, logic [7:0] c);
        out_t o;
        o.sd = s; o.rise = r; o.fall = f; o.ack = a; o.rdy = y; o.cur = c;
        return o;
    endfunction

    function automatic void row(logic r, logic q, logic [7:0] d, logic s,
                                logic ri, logic fa, logic a, logic [7:0] c);
        vec_t v;
        v.run = r; v.req = q; v.div = d;
        v.e = mk(s, ri, fa, a, 1'b1, c);
        tbl.push_back(v);
    endfunction

    task automatic step(input out_t e, input string nm);
        out_t got;
        out_t exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {sd, rise, fall, ack, rdy, cur};
        exp = sb.pop_front();
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got sd=%0b rise=%0b fall=%0b ack=%0b rdy=%0b cur=%0d, want sd=%0b rise=%0b fall=%0b ack=%0b rdy=%0b cur=%0d",
                     nm, got.sd, got.rise, got.fall, got.ack, got.rdy, got.cur,
                     exp.sd, exp.rise, exp.fall, exp.ack, exp.rdy, exp.cur);
        end
    endtask

    initial begin
        // steady div=2, then 2->4 at boundary, 4->1 requested mid high phase
        row(1,0,2, 1,1,0,0,2); row(1,0,2, 1,0,0,0,2);
        row(1,0,2, 0,0,1,0,2); row(1,0,2, 0,0,0,0,2);
        row(1,0,2, 1,1,0,0,2); row(1,1,4, 1,0,0,0,2);
        row(1,1,4, 0,0,1,0,2); row(1,1,4, 0,0,0,0,2);
        row(1,1,4, 1,1,0,1,4); row(1,0,4, 1,0,0,0,4);
        row(1,0,4, 1,0,0,0,4); row(1,0,4, 1,0,0,0,4);
        row(1,0,4, 0,0,1,0,4); row(1,0,4, 0,0,0,0,4);
        row(1,0,4, 0,0,0,0,4); row(1,0,4, 0,0,0,0,4);
        row(1,0,4, 1,1,0,0,4); row(1,1,1, 1,0,0,0,4);
        row(1,1,1, 1,0,0,0,4); row(1,1,1, 1,0,0,0,4);
        row(1,1,1, 0,0,1,0,4); row(1,1,1, 0,0,0,0,4);
        row(1,1,1, 0,0,0,0,4); row(1,1,1, 0,0,0,0,4);
        row(1,1,1, 1,1,0,1,1); row(1,0,1, 0,0,1,0,1);
        row(1,0,1, 1,1,0,0,1); row(1,0,1, 0,0,1,0,1);
        row(1,0,1, 1,1,0,0,1);
        // div=0 request maps to 1
        row(1,1,0, 0,0,1,0,1); row(1,1,0, 1,1,0,1,1);
        row(1,0,0, 0,0,1,0,1);
        // div=3, run drops one cycle into high phase
        row(1,1,3, 1,1,0,1,3); row(0,0,3, 1,0,0,0,3);
        row(0,0,3, 1,0,0,0,3); row(0,0,3, 0,0,1,0,3);
        row(0,0,3, 0,0,0,0,3); row(0,0,3, 0,0,0,0,3);
        row(0,0,3, 0,0,0,0,3); row(0,0,3, 0,0,0,0,3);
        // req+run together from IDLE: new div used for first high phase
        row(1,1,2, 1,1,0,1,2); row(1,0,2, 1,0,0,0,2);
        row(1,0,2, 0,0,1,0,2); row(1,0,2, 0,0,0,0,2);
        row(1,0,2, 1,1,0,0,2);

        rst_n = 1'b0; lock = 1'b0; run = 1'b0;
        req = 1'b0; div = 8'd0; hold = 1'b0;
        step(mk(0,0,0,0,0,8'd250), "reset0");
        step(mk(0,0,0,0,0,8'd250), "reset1");

        // startup with a one-cycle lock dropout at cycle 10
        rst_n = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            lock = (k == 10) ? 1'b0 : 1'b1;
            step(mk(0,0,0,0,(k >= 27),8'd250), $sformatf("startup%0d", k));
        end

        // IDLE load; req held past ack is re-served one cycle later
        req = 1'b1; div = 8'd2;
        step(mk(0,0,0,1,1,8'd2), "idle_ack");
        step(mk(0,0,0,0,1,8'd2), "idle_noack");
        step(mk(0,0,0,1,1,8'd2), "idle_reack");
        req = 1'b0;
        step(mk(0,0,0,0,1,8'd2), "idle_drop");

        foreach (tbl[i]) begin
            run = tbl[i].run; req = tbl[i].req; div = tbl[i].div;
            step(tbl[i].e, $sformatf("vec%0d", i));
        end

        // lock loss while high with a pending request
        lock = 1'b0; run = 1'b1; req = 1'b1; div = 8'd5;
        step(mk(0,0,0,0,0,8'd2), "lockloss");
        lock = 1'b1; run = 1'b0; req = 1'b0;
        for (int k = 1; k <= 18; k++)
            step(mk(0,0,0,0,(k >= 17),8'd2), $sformatf("relock%0d", k));

`ifdef SD_CLK_STRETCH_EN
        run = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            hold = (k >= 5 && k <= 9);
            step(mk((k <= 2) || (k >= 10), (k == 1) || (k == 10), (k == 3),
                    0, 1, 8'd2), $sformatf("stretch%0d", k));
        end
        hold = 1'b0;
`else
        run = 1'b1;
        step(mk(1,1,0,0,1,8'd2), "run_again");
`endif

        // reset mid-period restores INIT_DIV
        rst_n = 1'b0;
        step(mk(0,0,0,0,0,8'd250), "midreset");
        rst_n = 1'b1;
        step(mk(0,0,0,0,0,8'd250), "postreset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
